// File: rtl/id_stage_pkg.sv
// Shared definitions for the ID stage: instruction field positions, opcode
// values, the ex_op encoding handed to EX, and the ID/EX control bundle.
package id_stage_pkg;

  // Instruction field bit positions
  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  // Primary opcode values found in instr[31:26]
  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_AND  = 6'd3;
  localparam logic [5:0] OP_OR   = 6'd4;
  localparam logic [5:0] OP_ADDI = 6'd5;
  localparam logic [5:0] OP_LW   = 6'd6;
  localparam logic [5:0] OP_SW   = 6'd7;
  localparam logic [5:0] OP_BEQ  = 6'd8;

  // Operation code presented to EX; mirrors the opcode numbering so that
  // EX can tell ADDI/LW/SW apart without re-reading the instruction.
  // Illegal opcodes collapse to EXOP_NOP.
  typedef enum logic [3:0] {
    EXOP_NOP  = 4'd0,
    EXOP_ADD  = 4'd1,
    EXOP_SUB  = 4'd2,
    EXOP_AND  = 4'd3,
    EXOP_OR   = 4'd4,
    EXOP_ADDI = 4'd5,
    EXOP_LW   = 4'd6,
    EXOP_SW   = 4'd7,
    EXOP_BEQ  = 4'd8
  } exOp_t;

  // Control bits carried in the ID/EX register
  typedef struct packed {
    logic regWrite;
    logic memRead;
    logic memWrite;
    logic branch;
    logic useImm;
  } ctrl_t;

endpackage

// File: rtl/id_hazard_unit.sv
// Combinational load-use hazard detection and writeback bypass muxes for
// the two source operands read in ID.
module id_hazard_unit
  import id_stage_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] i_rs,
  input  logic [ADDR_W-1:0] i_rt,
  input  logic              i_usesRs,
  input  logic              i_usesRt,
  input  logic              i_ifValid,
  input  logic              i_flush,
  input  logic              i_exValid,
  input  logic              i_exMemRead,
  input  logic [ADDR_W-1:0] i_exRd,
  input  logic [DATA_W-1:0] i_rf0Data,
  input  logic [DATA_W-1:0] i_rf1Data,
  input  logic              i_wbWena,
  input  logic [ADDR_W-1:0] i_wbWaddr,
  input  logic [DATA_W-1:0] i_wbWdata,
  output logic              o_stall,
  output logic [DATA_W-1:0] o_opA,
  output logic [DATA_W-1:0] o_opB
);

  logic w_rsHit;
  logic w_rtHit;

  // Load in EX whose result is needed by the instruction now in ID; a flush
  // squashes ID anyway, so it overrides the stall.
  always_comb begin
    w_rsHit = i_usesRs && (i_exRd == i_rs);
    w_rtHit = i_usesRt && (i_exRd == i_rt);
    o_stall = !i_flush && i_ifValid && i_exValid && i_exMemRead &&
              (i_exRd != '0) && (w_rsHit || w_rtHit);
  end

  // Operand A: register 0 is hardwired to zero, otherwise a writeback to
  // the same register this cycle wins over the (stale) register file data.
  always_comb begin
    o_opA = i_rf0Data;
    if (i_rs == '0) begin
      o_opA = '0;
    end else if (i_wbWena && (i_wbWaddr == i_rs)) begin
      o_opA = i_wbWdata;
    end
  end

  // Operand B: same selection rule as operand A, keyed on rt.
  always_comb begin
    o_opB = i_rf1Data;
    if (i_rt == '0) begin
      o_opB = '0;
    end else if (i_wbWena && (i_wbWaddr == i_rt)) begin
      o_opB = i_wbWdata;
    end
  end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: drives the register file read ports, decodes the
// instruction from IF, stalls IF on load-use hazards and fills the ID/EX
// pipeline register.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int PC_W   = 9
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [31:0]       i_if_instr,
  input  logic [PC_W-1:0]   i_if_pc,
  input  logic              i_if_valid,
  input  logic              i_flush,
  output logic              o_stall,
  output logic [ADDR_W-1:0] o_rf_r0addr,
  output logic [ADDR_W-1:0] o_rf_r1addr,
  input  logic [DATA_W-1:0] i_rf_r0data,
  input  logic [DATA_W-1:0] i_rf_r1data,
  input  logic              i_wb_wena,
  input  logic [ADDR_W-1:0] i_wb_waddr,
  input  logic [DATA_W-1:0] i_wb_wdata,
  output logic              o_ex_valid,
  output logic [3:0]        o_ex_op,
  output logic [PC_W-1:0]   o_ex_pc,
  output logic [ADDR_W-1:0] o_ex_rd,
  output logic [DATA_W-1:0] o_ex_rs_data,
  output logic [DATA_W-1:0] o_ex_rt_data,
  output logic [DATA_W-1:0] o_ex_imm,
  output logic              o_ex_regwrite,
  output logic              o_ex_memread,
  output logic              o_ex_memwrite,
  output logic              o_ex_branch,
  output logic              o_ex_useimm,
  output logic              o_illegal_instr
);

  // Instruction fields
  logic [5:0]        w_opcode;
  logic [ADDR_W-1:0] w_rs;
  logic [ADDR_W-1:0] w_rt;
  logic [ADDR_W-1:0] w_rdField;
  logic [15:0]       w_imm16;

  // Decode results
  exOp_t             w_exOp;
  ctrl_t             w_ctrl;
  logic [ADDR_W-1:0] w_destReg;
  logic              w_usesRs;
  logic              w_usesRt;
  logic              w_illegal;

  // Hazard / bypass results
  logic              w_stall;
  logic [DATA_W-1:0] w_opA;
  logic [DATA_W-1:0] w_opB;

  // ID/EX pipeline register
  logic              r_exValid;
  exOp_t             r_exOp;
  logic [PC_W-1:0]   r_exPc;
  logic [ADDR_W-1:0] r_exRd;
  logic [DATA_W-1:0] r_exRsData;
  logic [DATA_W-1:0] r_exRtData;
  logic [DATA_W-1:0] r_exImm;
  ctrl_t             r_exCtrl;
  logic              r_illegal;

  // Slice the instruction; the read ports follow rs/rt every cycle.
  always_comb begin
    w_opcode    = i_if_instr[OP_HI:OP_LO];
    w_rs        = i_if_instr[RS_HI:RS_LO];
    w_rt        = i_if_instr[RT_HI:RT_LO];
    w_rdField   = i_if_instr[RD_HI:RD_LO];
    w_imm16     = i_if_instr[IMM_HI:IMM_LO];
    o_rf_r0addr = w_rs;
    o_rf_r1addr = w_rt;
  end

  // Opcode decode: control bits, destination register and source usage.
  // Unknown opcodes behave exactly like NOP apart from the illegal flag.
  always_comb begin
    w_exOp    = EXOP_NOP;
    w_ctrl    = '0;
    w_destReg = '0;
    w_usesRs  = 1'b0;
    w_usesRt  = 1'b0;
    w_illegal = 1'b0;
    case (w_opcode)
      OP_NOP: begin
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        w_exOp          = exOp_t'(w_opcode[3:0]);
        w_ctrl.regWrite = 1'b1;
        w_destReg       = w_rdField;
        w_usesRs        = 1'b1;
        w_usesRt        = 1'b1;
      end
      OP_ADDI: begin
        w_exOp          = EXOP_ADDI;
        w_ctrl.regWrite = 1'b1;
        w_ctrl.useImm   = 1'b1;
        w_destReg       = w_rt;
        w_usesRs        = 1'b1;
      end
      OP_LW: begin
        w_exOp          = EXOP_LW;
        w_ctrl.regWrite = 1'b1;
        w_ctrl.memRead  = 1'b1;
        w_ctrl.useImm   = 1'b1;
        w_destReg       = w_rt;
        w_usesRs        = 1'b1;
      end
      OP_SW: begin
        w_exOp          = EXOP_SW;
        w_ctrl.memWrite = 1'b1;
        w_ctrl.useImm   = 1'b1;
        w_usesRs        = 1'b1;
        w_usesRt        = 1'b1;
      end
      OP_BEQ: begin
        w_exOp          = EXOP_BEQ;
        w_ctrl.branch   = 1'b1;
        w_usesRs        = 1'b1;
        w_usesRt        = 1'b1;
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  id_hazard_unit #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_hazard (
    .i_rs        (w_rs),
    .i_rt        (w_rt),
    .i_usesRs    (w_usesRs),
    .i_usesRt    (w_usesRt),
    .i_ifValid   (i_if_valid),
    .i_flush     (i_flush),
    .i_exValid   (r_exValid),
    .i_exMemRead (r_exCtrl.memRead),
    .i_exRd      (r_exRd),
    .i_rf0Data   (i_rf_r0data),
    .i_rf1Data   (i_rf_r1data),
    .i_wbWena    (i_wb_wena),
    .i_wbWaddr   (i_wb_waddr),
    .i_wbWdata   (i_wb_wdata),
    .o_stall     (w_stall),
    .o_opA       (w_opA),
    .o_opB       (w_opB)
  );

  // ID/EX register: reset and flush/stall/invalid all insert a fully zeroed
  // bubble; otherwise the decoded instruction is captured.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush || w_stall || !i_if_valid) begin
      r_exValid  <= 1'b0;
      r_exOp     <= EXOP_NOP;
      r_exPc     <= '0;
      r_exRd     <= '0;
      r_exRsData <= '0;
      r_exRtData <= '0;
      r_exImm    <= '0;
      r_exCtrl   <= '0;
      r_illegal  <= 1'b0;
    end else begin
      r_exValid  <= 1'b1;
      r_exOp     <= w_exOp;
      r_exPc     <= i_if_pc;
      r_exRd     <= w_destReg;
      r_exRsData <= w_opA;
      r_exRtData <= w_opB;
      r_exImm    <= {{(DATA_W-16){w_imm16[15]}}, w_imm16};
      r_exCtrl   <= w_ctrl;
      r_illegal  <= w_illegal;
    end
  end

  // Present the pipeline register to EX.
  always_comb begin
    o_stall         = w_stall;
    o_ex_valid      = r_exValid;
    o_ex_op         = r_exOp;
    o_ex_pc         = r_exPc;
    o_ex_rd         = r_exRd;
    o_ex_rs_data    = r_exRsData;
    o_ex_rt_data    = r_exRtData;
    o_ex_imm        = r_exImm;
    o_ex_regwrite   = r_exCtrl.regWrite;
    o_ex_memread    = r_exCtrl.memRead;
    o_ex_memwrite   = r_exCtrl.memWrite;
    o_ex_branch     = r_exCtrl.branch;
    o_ex_useimm     = r_exCtrl.useImm;
    o_illegal_instr = r_illegal;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the five-stage pipeline.
- Drives the register file read addresses, bypasses same-cycle writeback data, and detects load-use hazards, stalling IF when needed.
- Registers the decoded operands and control into the ID/EX pipeline register consumed by the EX stage.
- Sits between the IF stage and EX, and is the sole driver of the register file read ports.

Parameters:
DATA_W, 64, operand/register width
ADDR_W, 5, register address width (32 registers)
PC_W, 9, program counter width

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
if_instr  in  32  instruction from IF
if_pc  in  PC_W  PC of if_instr
if_valid  in  1  if_instr is a real instruction
flush  in  1  branch taken in EX; squash ID contents
stall  out  1  combinational; IF must hold PC and if_instr
rf_r0addr  out  ADDR_W  register file read port 0 address (= rs)
rf_r1addr  out  ADDR_W  register file read port 1 address (= rt)
rf_r0data  in  DATA_W  register file read data 0 (combinational)
rf_r1data  in  DATA_W  register file read data 1
wb_wena  in  1  writeback write enable (same signal driving the register file)
wb_waddr  in  ADDR_W  writeback address
wb_wdata  in  DATA_W  writeback data
ex_valid  out  1  ID/EX holds a real instruction
ex_op  out  4  decoded ALU/branch op code
ex_pc  out  PC_W  PC of instruction
ex_rd  out  ADDR_W  destination register
ex_rs_data  out  DATA_W  operand A
ex_rt_data  out  DATA_W  operand B / store data
ex_imm  out  DATA_W  sign-extended imm16
ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_useimm  out  1 each  control
illegal_instr  out  1  one-cycle pulse, registered with the instruction

Behaviour:
- Instruction format: op[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0].
- Opcodes:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR (rd <- rs op rt)
  - 5 ADDI (rt <- rs+imm)
  - 6 LW (rt <- mem[rs+imm])
  - 7 SW (mem[rs+imm] <- rt)
  - 8 BEQ (rs, rt, imm)
- Any other opcode decodes as NOP with illegal_instr=1 in the same registered cycle.
- Destination: R-type uses rd; ADDI/LW use rt. SW/BEQ/NOP have regwrite=0.
- Source use: uses_rs for all ops except NOP; uses_rt for R-type, SW, BEQ.
- Read addressing: rf_r0addr=rs, rf_r1addr=rt, driven combinationally from if_instr every cycle.
- Bypass: if wb_wena and wb_waddr==rs and rs!=0, operand A = wb_wdata; otherwise rf_r0data. Same rule for rt/operand B. Needed because a register file write lands at the same edge as the ID/EX capture.
- Register 0 always yields 0, regardless of rf data or bypass.
- Load-use hazard: stall=1 iff all of the following hold:
  - if_valid and ex_valid and ex_memread;
  - ex_rd!=0;
  - (uses_rs and ex_rd==rs) or (uses_rt and ex_rd==rt).
- Next ID/EX content, in priority order:
  - reset: all ex_* outputs and illegal_instr = 0.
  - flush: bubble (ex_valid=0, all controls 0, data 0). stall is forced 0 while flush=1.
  - stall: bubble inserted; IF holds; the same instruction re-decodes next cycle.
  - !if_valid: bubble.
  - otherwise: capture the decoded instruction, with ex_valid=1.
- Latency: 1 cycle, if_instr to ex_*.
- Bubble: a stall costs exactly one bubble per load-use pair. After the bubble, ex_memread=0, so stall releases the following cycle.
- Sign extension: ex_imm = {{48{imm[15]}}, imm}.
- Reset mid-stall: stall drops combinationally, because ex_valid is 0 after reset.

Decomposition:
- Shared package: opcode constants (OP_NOP..OP_BEQ), ex_op encodings, field bit positions, ID/EX control bundle struct.
- One natural sub-module, id_hazard_unit: combinational load-use detect plus bypass muxes.
- Decode and the pipeline register stay in id_stage.

Test Plan:
- Reset, then ADD r3=r1+r2 with rf data 1,2 -> next cycle ex_valid=1, ex_rd=3, ex_rs_data=1, ex_rt_data=2, ex_regwrite=1.
- ADDI r4=r1+0xFFFF -> ex_imm=64'hFFFF_FFFF_FFFF_FFFF, ex_useimm=1, ex_rd=4.
- Same-cycle bypass: wb_wena=1, wb_waddr=2, wb_wdata=99 with ADD rs=2 -> ex_rs_data=99. Repeat with waddr=0, rs=0 -> 0.
- LW r5 in EX, then SUB r6=r5-r1 in ID -> stall=1 for one cycle with a bubble (ex_valid=0); next cycle SUB captured, stall=0.
- flush=1 coincident with a load-use hazard -> stall=0, ex_valid=0 next cycle.
- Opcode 0x3F -> illegal_instr=1 for one cycle, ex_regwrite=0, ex_memwrite=0.
